// File: rtl/ppu_palette_ram_responder.sv
// PPU palette RAM slave: 32-entry store, 1-cycle read port, buffered CPU writes, init sweep.
// Define PAL_DEFAULT_INIT_EN to load the power-up palette table during the sweep instead of zeros.
module ppu_palette_ram_responder #(
  parameter logic [15:0] PAL_BASE = 16'h3F00,
  parameter int unsigned ENTRY_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] vram_addr_in,
  output logic [7:0]  vram_data_out,
  output logic        vram_hit,
  input  logic        cpu_wr_valid,
  output logic        cpu_wr_ready,
  input  logic [15:0] cpu_wr_addr,
  input  logic [7:0]  cpu_wr_data,
  output logic        init_busy
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t               state;
  logic [4:0]           init_cnt;
  logic                 buf_valid;
  logic [4:0]           buf_idx;
  logic [ENTRY_W-1:0]   buf_data;

  logic [ENTRY_W-1:0]   mem [32];

  logic [4:0]           rd_idx;
  logic                 rd_hit;
  logic [ENTRY_W-1:0]   rd_entry;
  logic [7:0]           rd_ext;
  logic [4:0]           wr_idx;
  logic                 wr_hit;
  logic                 wr_accept;
  logic                 mem_we;
  logic [4:0]           mem_waddr;
  logic [ENTRY_W-1:0]   mem_wdata;
  logic                 unused_bits;

  // Entries whose low two index bits are zero are shared between the two halves.
  function automatic logic [4:0] pal_idx(input logic [15:0] a);
    logic [4:0] i;
    i = a[4:0];
    if (i[1:0] == 2'b00) i[4] = 1'b0;
    return i;
  endfunction

  function automatic logic in_window(input logic [15:0] a);
    return a[15:8] == PAL_BASE[15:8];
  endfunction

  function automatic logic [ENTRY_W-1:0] init_value(input logic [4:0] i);
    logic [7:0] v;
    v = '0;
`ifdef PAL_DEFAULT_INIT_EN
    case (i)
      5'd0:  v = 8'h09;
      5'd1:  v = 8'h01;
      5'd2:  v = 8'h00;
      5'd3:  v = 8'h01;
      5'd4:  v = 8'h00;
      5'd5:  v = 8'h02;
      5'd6:  v = 8'h02;
      5'd7:  v = 8'h0D;
      5'd8:  v = 8'h08;
      5'd9:  v = 8'h10;
      5'd10: v = 8'h08;
      5'd11: v = 8'h24;
      5'd12: v = 8'h00;
      5'd13: v = 8'h00;
      5'd14: v = 8'h04;
      5'd15: v = 8'h2C;
      5'd16: v = 8'h09;
      5'd17: v = 8'h01;
      5'd18: v = 8'h34;
      5'd19: v = 8'h03;
      5'd20: v = 8'h00;
      5'd21: v = 8'h04;
      5'd22: v = 8'h00;
      5'd23: v = 8'h14;
      5'd24: v = 8'h08;
      5'd25: v = 8'h3A;
      5'd26: v = 8'h00;
      5'd27: v = 8'h02;
      5'd28: v = 8'h00;
      5'd29: v = 8'h20;
      5'd30: v = 8'h2C;
      default: v = 8'h08;
    endcase
`else
    v = {3'b000, i} & 8'h00;
`endif
    return v[ENTRY_W-1:0];
  endfunction

  assign unused_bits = &{1'b0, vram_addr_in[7:5], cpu_wr_addr[7:5], cpu_wr_data[7:ENTRY_W]};

  assign rd_idx    = pal_idx(vram_addr_in);
  assign rd_hit    = in_window(vram_addr_in);
  assign wr_idx    = pal_idx(cpu_wr_addr);
  assign wr_hit    = in_window(cpu_wr_addr);
  assign wr_accept = cpu_wr_valid & cpu_wr_ready;

  // Only the already-buffered write is forwarded; an accept on this edge is seen next read.
  always_comb begin
    rd_entry = mem[rd_idx];
    if (buf_valid && (buf_idx == rd_idx)) rd_entry = buf_data;
  end

  always_comb begin
    rd_ext = '0;
    rd_ext[ENTRY_W-1:0] = rd_entry;
  end

  // Single store write port: the sweep owns it in INIT, the write buffer in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = init_value(init_cnt);
    end else if (buf_valid) begin
      mem_we    = 1'b1;
      mem_waddr = buf_idx;
      mem_wdata = buf_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_INIT;
      init_cnt      <= '0;
      buf_valid     <= 1'b0;
      buf_idx       <= '0;
      buf_data      <= '0;
      vram_data_out <= '0;
      vram_hit      <= 1'b0;
      cpu_wr_ready  <= 1'b0;
      init_busy     <= 1'b1;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt      <= init_cnt + 5'd1;
          buf_valid     <= 1'b0;
          vram_data_out <= '0;
          vram_hit      <= 1'b0;
          if (init_cnt == 5'd31) begin
            state        <= S_RUN;
            init_busy    <= 1'b0;
            cpu_wr_ready <= 1'b1;
          end
        end
        S_RUN: begin
          vram_hit      <= rd_hit;
          vram_data_out <= rd_hit ? rd_ext : '0;
          buf_valid     <= wr_accept & wr_hit;
          if (wr_accept && wr_hit) begin
            buf_idx  <= wr_idx;
            buf_data <= cpu_wr_data[ENTRY_W-1:0];
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_palette_ram_responder.sv
// Directed bench for ppu_palette_ram_responder: init timing, mirroring, bypass, conflicts, reset abort.
module tb_ppu_palette_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] vram_addr_in = '0;
  logic [7:0]  vram_data_out;
  logic        vram_hit;
  logic        cpu_wr_valid = 1'b0;
  logic        cpu_wr_ready;
  logic [15:0] cpu_wr_addr = '0;
  logic [7:0]  cpu_wr_data = '0;
  logic        init_busy;

  int total = 0;
  int bad   = 0;

`ifdef PAL_DEFAULT_INIT_EN
  localparam logic [7:0] E1 = 8'h01, E5 = 8'h02, E10 = 8'h08, E14 = 8'h04;
`else
  localparam logic [7:0] E1 = 8'h00, E5 = 8'h00, E10 = 8'h00, E14 = 8'h00;
`endif

  ppu_palette_ram_responder #(.PAL_BASE(16'h3F00), .ENTRY_W(6)) dut (
    .clk(clk), .rst(rst),
    .vram_addr_in(vram_addr_in), .vram_data_out(vram_data_out), .vram_hit(vram_hit),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] ed, input logic eh, input string tag);
    vram_addr_in = a;
    tick();
    check({tag, "_d"}, {8'h00, vram_data_out}, {8'h00, ed});
    check({tag, "_h"}, {15'h0, vram_hit}, {15'h0, eh});
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = a;
    cpu_wr_data  = d;
    tick();
    cpu_wr_valid = 1'b0;
  endtask

  // Counts edges until init_busy drops; outputs must stay quiet the whole time.
  task automatic wait_init(input string tag);
    int n;
    logic noisy;
    n = 0;
    noisy = 1'b0;
    vram_addr_in = 16'h3F05;
    do begin
      if (cpu_wr_ready || vram_hit || (vram_data_out != 8'h00)) noisy = 1'b1;
      tick();
      n++;
    end while (init_busy && n < 100);
    check({tag, "_busy_cycles"}, 16'(n), 16'd32);
    check({tag, "_quiet"}, {15'h0, noisy}, 16'h0);
    check({tag, "_ready"}, {15'h0, cpu_wr_ready}, 16'h1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_data",  {8'h00, vram_data_out}, 16'h0);
    check("rst_hit",   {15'h0, vram_hit}, 16'h0);
    check("rst_ready", {15'h0, cpu_wr_ready}, 16'h0);
    check("rst_busy",  {15'h0, init_busy}, 16'h1);
    rst = 1'b0;
    wait_init("init1");
    rd(16'h3F05, E5, 1'b1, "init_3f05");

    wr(16'h3F01, 8'hFF);
    tick();
    rd(16'h3F01, 8'h3F, 1'b1, "trunc_3f01");

    wr(16'h3F10, 8'h2A);
    rd(16'h3F00, 8'h2A, 1'b1, "mir_3f00");
    rd(16'h3F10, 8'h2A, 1'b1, "mir_3f10");
    rd(16'h3F20, 8'h2A, 1'b1, "wrap_3f20");
    wr(16'h3F14, 8'h15);
    rd(16'h3F04, 8'h15, 1'b1, "mir_3f04");

    wr(16'h3F07, 8'h11);
    rd(16'h3F07, 8'h11, 1'b1, "bypass_3f07");

    // Buffered value wins over a same-edge accept to the same index.
    wr(16'h3F09, 8'h0A);
    cpu_wr_valid = 1'b1; cpu_wr_addr = 16'h3F09; cpu_wr_data = 8'h0B;
    rd(16'h3F09, 8'h0A, 1'b1, "conflict_old");
    cpu_wr_valid = 1'b0;
    rd(16'h3F09, 8'h0B, 1'b1, "conflict_new");

    // An accept alone is not forwarded to a read on the same edge.
    tick();
    cpu_wr_valid = 1'b1; cpu_wr_addr = 16'h3F0A; cpu_wr_data = 8'h12;
    rd(16'h3F0A, E10, 1'b1, "incoming_hidden");
    cpu_wr_valid = 1'b0;
    rd(16'h3F0A, 8'h12, 1'b1, "incoming_later");

    cpu_wr_valid = 1'b1;
    cpu_wr_addr = 16'h3F02; cpu_wr_data = 8'h01; tick();
    cpu_wr_addr = 16'h3F03; cpu_wr_data = 8'h02; tick();
    cpu_wr_addr = 16'h3F02; cpu_wr_data = 8'h03; tick();
    cpu_wr_valid = 1'b0;
    tick();
    rd(16'h3F02, 8'h03, 1'b1, "b2b_3f02");
    rd(16'h3F03, 8'h02, 1'b1, "b2b_3f03");

    rd(16'h2000, 8'h00, 1'b0, "miss_2000");
    check("miss_ready", {15'h0, cpu_wr_ready}, 16'h1);
    wr(16'h2000, 8'h55);
    tick();
    rd(16'h3F00, 8'h2A, 1'b1, "miss_wr_3f00");

    wr(16'h3F0E, 8'h3E);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  {15'h0, init_busy}, 16'h1);
    check("mid_rst_ready", {15'h0, cpu_wr_ready}, 16'h0);
    check("mid_rst_data",  {8'h00, vram_data_out}, 16'h0);
    tick();
    rst = 1'b0;
    wait_init("init2");
    rd(16'h3F0E, E14, 1'b1, "reinit_3f0e");
    rd(16'h3F01, E1, 1'b1, "reinit_3f01");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
